// File: rtl/alu_rs_multi.sv
// Multi-entry ALU reservation station: dispatch into free slots, CDB operand snoop,
// oldest-ready issue to a single-cycle ADD/SUB path or a pipelined multiplier.
module alu_rs_multi #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned RB_INDEX    = 4,
  parameter int unsigned RB_SIZE     = 16,
  parameter int unsigned ENTRIES     = 4,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [1:0]                       disp_op,
  input  logic [RB_INDEX-1:0]              disp_dest,
  input  logic [WORD_SIZE-1:0]             disp_vj,
  input  logic [WORD_SIZE-1:0]             disp_vk,
  input  logic                             disp_rj,
  input  logic                             disp_rk,
  input  logic [RB_INDEX-1:0]              disp_qj,
  input  logic [RB_INDEX-1:0]              disp_qk,
  input  logic [WORD_SIZE*RB_SIZE-1:0]     cdb_data,
  input  logic [RB_SIZE-1:0]               cdb_valid,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [WORD_SIZE-1:0]             res_data,
  output logic [RB_INDEX-1:0]              res_dest,
  output logic                             busy_out,
  output logic [$clog2(ENTRIES+1)-1:0]     count
);

  localparam int unsigned CW       = $clog2(ENTRIES + 1);
  localparam int unsigned AW       = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned PD       = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
  localparam bit          MUL_PIPE = (MUL_LATENCY > 1);

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  // Station slots
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [ENTRIES-1:0]   rj_q, rj_d, rk_q, rk_d;
  logic [1:0]           op_q   [ENTRIES];
  logic [1:0]           op_d   [ENTRIES];
  logic [RB_INDEX-1:0]  dest_q [ENTRIES];
  logic [RB_INDEX-1:0]  dest_d [ENTRIES];
  logic [RB_INDEX-1:0]  qj_q   [ENTRIES];
  logic [RB_INDEX-1:0]  qj_d   [ENTRIES];
  logic [RB_INDEX-1:0]  qk_q   [ENTRIES];
  logic [RB_INDEX-1:0]  qk_d   [ENTRIES];
  logic [WORD_SIZE-1:0] vj_q   [ENTRIES];
  logic [WORD_SIZE-1:0] vj_d   [ENTRIES];
  logic [WORD_SIZE-1:0] vk_q   [ENTRIES];
  logic [WORD_SIZE-1:0] vk_d   [ENTRIES];
  logic [AW-1:0]        age_q  [ENTRIES];
  logic [AW-1:0]        age_d  [ENTRIES];

  logic [CW-1:0]        count_q, count_d;
  logic                 disp_ready_q, disp_ready_d;

  // Multiplier pipeline and result register
  logic [PD-1:0]        pv_q, pv_d;
  logic [WORD_SIZE-1:0] pdat_q [PD];
  logic [WORD_SIZE-1:0] pdat_d [PD];
  logic [RB_INDEX-1:0]  pdst_q [PD];
  logic [RB_INDEX-1:0]  pdst_d [PD];
  logic                 res_valid_q, res_valid_d;
  logic [WORD_SIZE-1:0] res_data_q, res_data_d;
  logic [RB_INDEX-1:0]  res_dest_q, res_dest_d;

  // Issue select signals
  logic                 stall_c, mul_done_c;
  logic                 iss_found_c, iss_fire_c;
  logic [AW-1:0]        iss_idx_c;
  logic [AW-1:0]        best_age_c;
  logic [1:0]           iss_op_c;
  logic [RB_INDEX-1:0]  iss_dest_c;
  logic [WORD_SIZE-1:0] alu_res_c, mul_res_c;
  logic                 iss_is_mul_c;

  logic                 disp_acc_c;
  logic [AW-1:0]        free_idx_c;
  logic [CW-1:0]        cnt_c;

  assign disp_ready = disp_ready_q;
  assign busy_out   = !disp_ready_q;
  assign count      = count_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_dest   = res_dest_q;

  // Oldest ready slot; ADD/SUB yields to a multiplier result leaving the pipe this edge
  always_comb begin
    stall_c     = res_valid_q && !res_ready;
    mul_done_c  = MUL_PIPE && pv_q[PD-1];
    iss_found_c = 1'b0;
    iss_idx_c   = '0;
    best_age_c  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && rj_q[i] && rk_q[i] && (op_q[i] == OP_MUL || !mul_done_c) &&
          (!iss_found_c || age_q[i] < best_age_c)) begin
        iss_found_c = 1'b1;
        iss_idx_c   = AW'(i);
        best_age_c  = age_q[i];
      end
    end
    iss_fire_c   = iss_found_c && !stall_c;
    iss_op_c     = op_q[iss_idx_c];
    iss_dest_c   = dest_q[iss_idx_c];
    iss_is_mul_c = (iss_op_c == OP_MUL);
    alu_res_c    = (iss_op_c == OP_SUB) ? vj_q[iss_idx_c] - vk_q[iss_idx_c]
                                        : vj_q[iss_idx_c] + vk_q[iss_idx_c];
    mul_res_c    = vj_q[iss_idx_c] * vk_q[iss_idx_c];
  end

  // Slot bookkeeping: snoop, issue release, age compaction, dispatch, flush
  always_comb begin
    valid_d    = valid_q;
    rj_d       = rj_q;
    rk_d       = rk_q;
    op_d       = op_q;
    dest_d     = dest_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    age_d      = age_q;
    free_idx_c = '0;
    cnt_c      = '0;
    disp_acc_c = disp_valid && disp_ready_q && !flush;

    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx_c = AW'(i);
    end

    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && !rj_q[i] && cdb_valid[qj_q[i]]) begin
        vj_d[i] = cdb_data[qj_q[i]*WORD_SIZE +: WORD_SIZE];
        rj_d[i] = 1'b1;
      end
      if (valid_q[i] && !rk_q[i] && cdb_valid[qk_q[i]]) begin
        vk_d[i] = cdb_data[qk_q[i]*WORD_SIZE +: WORD_SIZE];
        rk_d[i] = 1'b1;
      end
      // Ages are ranks among occupied slots; close the gap left by the issued slot
      if (iss_fire_c && valid_q[i] && age_q[i] > age_q[iss_idx_c]) age_d[i] = age_q[i] - AW'(1);
      if (iss_fire_c && iss_idx_c == AW'(i)) valid_d[i] = 1'b0;
    end

    if (disp_acc_c && disp_op != OP_RSV) begin
      valid_d[free_idx_c] = 1'b1;
      op_d[free_idx_c]    = disp_op;
      dest_d[free_idx_c]  = disp_dest;
      qj_d[free_idx_c]    = disp_qj;
      qk_d[free_idx_c]    = disp_qk;
      age_d[free_idx_c]   = AW'(count_q - CW'(iss_fire_c));
      if (disp_rj || cdb_valid[disp_qj]) begin
        vj_d[free_idx_c] = disp_rj ? disp_vj : cdb_data[disp_qj*WORD_SIZE +: WORD_SIZE];
        rj_d[free_idx_c] = 1'b1;
      end else begin
        vj_d[free_idx_c] = disp_vj;
        rj_d[free_idx_c] = 1'b0;
      end
      if (disp_rk || cdb_valid[disp_qk]) begin
        vk_d[free_idx_c] = disp_rk ? disp_vk : cdb_data[disp_qk*WORD_SIZE +: WORD_SIZE];
        rk_d[free_idx_c] = 1'b1;
      end else begin
        vk_d[free_idx_c] = disp_vk;
        rk_d[free_idx_c] = 1'b0;
      end
    end

    if (flush) valid_d = '0;

    for (int i = 0; i < ENTRIES; i++) cnt_c = cnt_c + CW'(valid_d[i]);
    count_d      = cnt_c;
    disp_ready_d = (cnt_c != CW'(ENTRIES));
  end

  // Multiplier pipeline advance and result register load
  always_comb begin
    pv_d        = pv_q;
    pdat_d      = pdat_q;
    pdst_d      = pdst_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_dest_d  = res_dest_q;
    if (!stall_c) begin
      for (int s = PD - 1; s >= 1; s--) begin
        pv_d[s]   = pv_q[s-1];
        pdat_d[s] = pdat_q[s-1];
        pdst_d[s] = pdst_q[s-1];
      end
      pv_d[0]   = MUL_PIPE && iss_fire_c && iss_is_mul_c;
      pdat_d[0] = mul_res_c;
      pdst_d[0] = iss_dest_c;
      if (mul_done_c) begin
        res_valid_d = 1'b1;
        res_data_d  = pdat_q[PD-1];
        res_dest_d  = pdst_q[PD-1];
      end else if (iss_fire_c && !(MUL_PIPE && iss_is_mul_c)) begin
        res_valid_d = 1'b1;
        res_data_d  = iss_is_mul_c ? mul_res_c : alu_res_c;
        res_dest_d  = iss_dest_c;
      end else begin
        res_valid_d = 1'b0;
      end
    end
    if (flush) begin
      pv_d        = '0;
      res_valid_d = 1'b0;
      res_data_d  = '0;
      res_dest_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      rj_q         <= '0;
      rk_q         <= '0;
      count_q      <= '0;
      disp_ready_q <= 1'b1;
      pv_q         <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_dest_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        age_q[i]  <= '0;
      end
      for (int s = 0; s < PD; s++) begin
        pdat_q[s] <= '0;
        pdst_q[s] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      rj_q         <= rj_d;
      rk_q         <= rk_d;
      count_q      <= count_d;
      disp_ready_q <= disp_ready_d;
      pv_q         <= pv_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_dest_q   <= res_dest_d;
      op_q         <= op_d;
      dest_q       <= dest_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      age_q        <= age_d;
      pdat_q       <= pdat_d;
      pdst_q       <= pdst_d;
    end
  end

endmodule

// File: tb/tb_alu_rs_multi.sv
// Directed bench for alu_rs_multi: per-scenario tasks with hand-computed expectations.
module tb_alu_rs_multi;

  localparam int unsigned WS = 32;
  localparam int unsigned RI = 4;
  localparam int unsigned RS = 16;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic              disp_valid, disp_ready;
  logic [1:0]        disp_op;
  logic [RI-1:0]     disp_dest, disp_qj, disp_qk;
  logic [WS-1:0]     disp_vj, disp_vk;
  logic              disp_rj, disp_rk;
  logic [WS*RS-1:0]  cdb_data;
  logic [RS-1:0]     cdb_valid;
  logic              res_valid, res_ready;
  logic [WS-1:0]     res_data;
  logic [RI-1:0]     res_dest;
  logic              busy_out;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  alu_rs_multi dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_dest(disp_dest), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_rj(disp_rj), .disp_rk(disp_rk), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_dest(res_dest),
    .busy_out(busy_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one dispatch across a single edge
  task automatic dispatch(input logic [1:0] op, input logic [RI-1:0] dest,
                          input logic [WS-1:0] vj, input logic [WS-1:0] vk,
                          input logic rj, input logic rk,
                          input logic [RI-1:0] qj, input logic [RI-1:0] qk);
    disp_valid = 1'b1; disp_op = op; disp_dest = dest;
    disp_vj = vj; disp_vk = vk; disp_rj = rj; disp_rk = rk; disp_qj = qj; disp_qk = qk;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_dest = '0;
    disp_vj = '0; disp_vk = '0; disp_rj = 1'b0; disp_rk = 1'b0; disp_qj = '0; disp_qk = '0;
    cdb_data = '0; cdb_valid = '0; res_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b exp 1", disp_ready); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
    checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data: got %h exp 0", res_data); end
    checks++; if (res_dest !== 4'd0) begin errors++; $display("FAIL reset_res_dest: got %h exp 0", res_dest); end
  endtask

  task automatic test_add();
    dispatch(2'd0, 4'd3, 32'd5, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL add_count_disp: got %0d exp 1", count); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b exp 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b exp 1", res_valid); end
    checks++; if (res_data !== 32'd12) begin errors++; $display("FAIL add_data: got %h exp c", res_data); end
    checks++; if (res_dest !== 4'd3) begin errors++; $display("FAIL add_dest: got %h exp 3", res_dest); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL add_count_after: got %0d exp 0", count); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_drained: got %b exp 0", res_valid); end
  endtask

  task automatic test_sub_mul();
    dispatch(2'd1, 4'd4, 32'd3, 32'd5, 1'b1, 1'b1, 4'd0, 4'd0);
    tick();
    checks++; if (res_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_data: got %h exp fffffffe", res_data); end
    checks++; if (res_dest !== 4'd4) begin errors++; $display("FAIL sub_dest: got %h exp 4", res_dest); end
    tick();
    dispatch(2'd2, 4'd5, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); // issue edge
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mul_early: got %b exp 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mul_valid: got %b exp 1", res_valid); end
    checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL mul_data: got %h exp 0", res_data); end
    checks++; if (res_dest !== 4'd5) begin errors++; $display("FAIL mul_dest: got %h exp 5", res_dest); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WS-1:0] exp_d;
    for (int i = 0; i < 4; i++)
      dispatch(2'd0, RI'(8 + i), 32'd0, WS'(i), 1'b0, 1'b1, 4'd2, 4'd0);
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b exp 1", busy_out); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b exp 0", disp_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d exp 4", count); end
    cdb_valid[2] = 1'b1; cdb_data[2*WS +: WS] = 32'd9;
    tick();
    cdb_valid = '0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fill_capture_valid: got %b exp 0", res_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = 32'd9 + WS'(i);
      checks++; if (res_data !== exp_d) begin errors++; $display("FAIL b2b_data%0d: got %h exp %h", i, res_data, exp_d); end
      checks++; if (res_dest !== RI'(8 + i)) begin errors++; $display("FAIL b2b_dest%0d: got %h exp %h", i, res_dest, 8 + i); end
      checks++; if (count !== 3'(3 - i)) begin errors++; $display("FAIL b2b_count%0d: got %0d exp %0d", i, count, 3 - i); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b exp 1", i, disp_ready); end
    end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b exp 0", res_valid); end
  endtask

  task automatic test_struct_hazard();
    dispatch(2'd2, 4'd1, 32'd6, 32'd7, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); // MUL issues (edge 0)
    dispatch(2'd0, 4'd2, 32'd1, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0); // edge 1
    tick(); // edge 2: MUL completes, ADD withheld
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL haz_mul_valid: got %b exp 1", res_valid); end
    checks++; if (res_data !== 32'd42) begin errors++; $display("FAIL haz_mul_data: got %h exp 2a", res_data); end
    checks++; if (res_dest !== 4'd1) begin errors++; $display("FAIL haz_mul_dest: got %h exp 1", res_dest); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL haz_add_held: got %0d exp 1", count); end
    tick(); // edge 3
    checks++; if (res_data !== 32'd3) begin errors++; $display("FAIL haz_add_data: got %h exp 3", res_data); end
    checks++; if (res_dest !== 4'd2) begin errors++; $display("FAIL haz_add_dest: got %h exp 2", res_dest); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL haz_count: got %0d exp 0", count); end
    tick();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    dispatch(2'd0, 4'd6, 32'd10, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0);
    dispatch(2'd0, 4'd7, 32'd20, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0);
    for (int c = 0; c < 5; c++) begin
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b exp 1", c, res_valid); end
      checks++; if (res_data !== 32'd11) begin errors++; $display("FAIL bp_data%0d: got %h exp b", c, res_data); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL bp_count%0d: got %0d exp 1", c, count); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    checks++; if (res_data !== 32'd22) begin errors++; $display("FAIL bp_release_data: got %h exp 16", res_data); end
    checks++; if (res_dest !== 4'd7) begin errors++; $display("FAIL bp_release_dest: got %h exp 7", res_dest); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_release_count: got %0d exp 0", count); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b exp 0", res_valid); end
  endtask

  task automatic test_bypass_flush();
    cdb_valid[5] = 1'b1; cdb_data[5*WS +: WS] = 32'd50;
    dispatch(2'd0, 4'd9, 32'd0, 32'd100, 1'b0, 1'b1, 4'd5, 4'd0);
    cdb_valid = '0;
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL byp_valid: got %b exp 1", res_valid); end
    checks++; if (res_data !== 32'd150) begin errors++; $display("FAIL byp_data: got %h exp 96", res_data); end
    checks++; if (res_dest !== 4'd9) begin errors++; $display("FAIL byp_dest: got %h exp 9", res_dest); end
    for (int i = 0; i < 3; i++)
      dispatch(2'd0, RI'(11 + i), 32'd0, 32'd1, 1'b0, 1'b1, 4'd7, 4'd0);
    dispatch(2'd2, 4'd10, 32'd3, 32'd3, 1'b1, 1'b1, 4'd0, 4'd0);
    tick(); // MUL issues into the pipeline
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fl_pre_count: got %0d exp 3", count); end
    flush = 1'b1;
    dispatch(2'd0, 4'd15, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0);
    flush = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl_count: got %0d exp 0", count); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b exp 1", disp_ready); end
    checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL fl_res_data: got %h exp 0", res_data); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fl_no_result%0d: got %b exp 0", c, res_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_back_to_back();
    test_struct_hazard();
    test_backpressure();
    test_bypass_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
